// File: rtl/alu_result_collector_if.sv
// Bundle of the ALU snoop inputs, the result-record stream and the status
// outputs of the result collector. The collector connects through the slave
// modport. Whatever drives the ALU side and consumes records connects through
// the master modport.
interface alu_result_collector_if #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              valid_in;
  logic [TAG_W-1:0]  pkt_num;
  logic              valid_out;
  logic [DATA_W-1:0] alu;
  logic              carry;
  logic              zero;
  logic              res_valid;
  logic              res_ready;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic              res_zero;
  logic [CNT_W-1:0]  in_flight;
  logic [15:0]       zero_cnt;
  logic              ovf_err;
  logic              tag_err;

  modport master (
    output valid_in, pkt_num, valid_out, alu, carry, zero, res_ready,
    input  res_valid, res_tag, res_data, res_carry, res_zero,
           in_flight, zero_cnt, ovf_err, tag_err
  );

  modport slave (
    input  valid_in, pkt_num, valid_out, alu, carry, zero, res_ready,
    output res_valid, res_tag, res_data, res_carry, res_zero,
           in_flight, zero_cnt, ovf_err, tag_err
  );
endinterface

// File: rtl/alu_result_collector.sv
// The collector snoops ALU issue tags into a tag FIFO. It pairs each ALU
// result with the oldest outstanding tag, in order, and queues the paired
// record in a first-word-fall-through result FIFO for a ready/valid consumer.
// DEPTH must be a power of two and at least 2, so the pointers wrap naturally.
module alu_result_collector #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_result_collector_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = TAG_W + DATA_W + 2;

  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [AW-1:0]    tag_wr;
  logic [AW-1:0]    tag_rd;
  logic [CW-1:0]    tag_cnt;

  logic [REC_W-1:0] res_mem [DEPTH];
  logic [AW-1:0]    res_wr;
  logic [AW-1:0]    res_rd;
  logic [CW-1:0]    res_cnt;

  logic [15:0]      zero_cnt_q;
  logic             ovf_q;
  logic             tag_err_q;

  logic             tag_empty;
  logic             tag_full;
  logic             tag_pop;
  logic             tag_push;
  logic             res_empty;
  logic             res_full;
  logic             res_pop;
  logic             res_push;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_head;

  // Push/pop decisions for both FIFOs. A pop frees a slot in the same cycle,
  // so a full FIFO still accepts a push when it is also being popped.
  always_comb begin
    tag_empty = (tag_cnt == '0);
    tag_full  = (tag_cnt == CW'(DEPTH));
    res_empty = (res_cnt == '0);
    res_full  = (res_cnt == CW'(DEPTH));
    tag_pop   = bus.valid_out && !tag_empty;
    tag_push  = bus.valid_in && (!tag_full || tag_pop);
    res_pop   = !res_empty && bus.res_ready;
    res_push  = tag_pop && (!res_full || res_pop);
    rec_in    = {tag_mem[tag_rd], bus.alu, bus.carry, bus.zero};
  end

  // Storage arrays. These need no reset because the pointers and counts
  // decide which entries are live.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr] <= bus.pkt_num;
    if (res_push) res_mem[res_wr] <= rec_in;
  end

  // Pointers, occupancy counts, the zero-result counter and the sticky
  // error flags. Reset takes priority over any traffic in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_wr     <= '0;
      tag_rd     <= '0;
      tag_cnt    <= '0;
      res_wr     <= '0;
      res_rd     <= '0;
      res_cnt    <= '0;
      zero_cnt_q <= '0;
      ovf_q      <= 1'b0;
      tag_err_q  <= 1'b0;
    end else begin
      if (tag_push) tag_wr <= tag_wr + 1'b1;
      if (tag_pop)  tag_rd <= tag_rd + 1'b1;
      tag_cnt <= tag_cnt + CW'(tag_push) - CW'(tag_pop);

      if (res_push) res_wr <= res_wr + 1'b1;
      if (res_pop)  res_rd <= res_rd + 1'b1;
      res_cnt <= res_cnt + CW'(res_push) - CW'(res_pop);

      if (res_push && bus.zero && (zero_cnt_q != 16'hFFFF))
        zero_cnt_q <= zero_cnt_q + 16'd1;

      if ((bus.valid_in && !tag_push) || (tag_pop && !res_push))
        ovf_q <= 1'b1;
      if (bus.valid_out && tag_empty)
        tag_err_q <= 1'b1;
    end
  end

  // The head record is forced to zero while the FIFO is empty, so stale
  // array contents never show on res_* (this includes just after reset).
  always_comb begin
    rec_head = res_empty ? '0 : res_mem[res_rd];
  end

  assign bus.res_valid = !res_empty;
  assign {bus.res_tag, bus.res_data, bus.res_carry, bus.res_zero} = rec_head;
  assign bus.in_flight = tag_cnt;
  assign bus.zero_cnt  = zero_cnt_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.tag_err   = tag_err_q;
endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector. A queue-based model keeps the expected
// outstanding tags and the expected result records. Records are pushed into
// the expected queue as results are driven, and are compared when the DUT
// hands them to the consumer.
module tb_alu_result_collector;
  localparam int DATA_W = 8;
  localparam int TAG_W  = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_result_collector_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

  alu_result_collector #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_rec = 0;
  logic        rdy_g = 1'b1;
  logic [7:0]  m_tag [$];
  logic [17:0] exp_q [$];
  logic        m_ovf = 1'b0;
  logic        m_terr = 1'b0;
  logic [15:0] m_zcnt = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one cycle of stimulus. Check the DUT against the model mid-cycle,
  // then advance the model across the coming edge.
  task automatic step(input logic rst, input logic vi, input logic [7:0] tg,
                      input logic vo, input logic [7:0] a, input logic c,
                      input logic z, input logic rdy);
    logic        tpop, tpush, rpop, rpush;
    logic [17:0] rec;
    reset         = rst;
    bus.valid_in  = vi;
    bus.pkt_num   = tg;
    bus.valid_out = vo;
    bus.alu       = a;
    bus.carry     = c;
    bus.zero      = z;
    bus.res_ready = rdy;
    @(negedge clk);
    check("res_valid", 64'(bus.res_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("record", 64'({bus.res_tag, bus.res_data, bus.res_carry, bus.res_zero}), 64'(exp_q[0]));
    check("in_flight", 64'(bus.in_flight), 64'(m_tag.size()));
    check("ovf_err", 64'(bus.ovf_err), 64'(m_ovf));
    check("tag_err", 64'(bus.tag_err), 64'(m_terr));
    check("zero_cnt", 64'(bus.zero_cnt), 64'(m_zcnt));
    if (!rst && bus.res_valid && rdy) n_rec++;
    if (rst) begin
      m_tag.delete();
      exp_q.delete();
      m_ovf  = 1'b0;
      m_terr = 1'b0;
      m_zcnt = '0;
      n_rec  = 0;
    end else begin
      tpop  = vo && (m_tag.size() != 0);
      tpush = vi && ((m_tag.size() < DEPTH) || tpop);
      rpop  = (exp_q.size() != 0) && rdy;
      rpush = tpop && ((exp_q.size() < DEPTH) || rpop);
      rec   = {(tpop ? m_tag[0] : 8'h00), a, c, z};
      if (rpop)  void'(exp_q.pop_front());
      if (tpop)  void'(m_tag.pop_front());
      if (tpush) m_tag.push_back(tg);
      if (rpush) exp_q.push_back(rec);
      if (rpush && z && (m_zcnt != 16'hFFFF)) m_zcnt = m_zcnt + 16'd1;
      if ((vi && !tpush) || (tpop && !rpush)) m_ovf = 1'b1;
      if (vo && !tpop) m_terr = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] t);
    step(1'b0, 1'b1, t, 1'b0, 8'h00, 1'b0, 1'b0, rdy_g);
  endtask

  task automatic result(input logic [7:0] a, input logic c, input logic z);
    step(1'b0, 1'b0, 8'h00, 1'b1, a, c, z, rdy_g);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, rdy_g);
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, 64'({bus.res_valid, bus.res_tag, bus.res_data, bus.res_carry, bus.res_zero,
                     bus.in_flight, bus.zero_cnt, bus.ovf_err, bus.tag_err}), 64'd0);
  endtask

  // Reset cycle with traffic on every input, so the bench confirms that
  // reset wins over same-cycle activity.
  task automatic do_reset();
    step(1'b1, 1'b1, 8'hAA, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
    check_zero_outputs("reset_outputs");
  endtask

  initial begin
    bus.valid_in  = 1'b0;
    bus.pkt_num   = '0;
    bus.valid_out = 1'b0;
    bus.alu       = '0;
    bus.carry     = 1'b0;
    bus.zero      = 1'b0;
    bus.res_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("initial_reset");

    // Three in-order results, consumer always ready.
    rdy_g = 1'b1;
    issue(8'd1); issue(8'd2); issue(8'd3);
    result(8'h05, 1'b0, 1'b0);
    result(8'h00, 1'b1, 1'b1);
    result(8'hFF, 1'b0, 1'b0);
    idle(2);
    check("basic_zero_cnt", 64'(bus.zero_cnt), 64'd1);
    check("basic_in_flight", 64'(bus.in_flight), 64'd0);
    check("basic_records", 64'(n_rec), 64'd3);

    // Tag FIFO overflow: the fifth issue is dropped.
    do_reset();
    for (int i = 1; i <= 5; i++) issue(8'(i));
    check("tagovf_in_flight", 64'(bus.in_flight), 64'd4);
    check("tagovf_ovf", 64'(bus.ovf_err), 64'd1);
    for (int i = 0; i < 4; i++) result(8'h10 + 8'(i), 1'b0, 1'b0);
    idle(2);
    check("tagovf_records", 64'(n_rec), 64'd4);

    // Result with no outstanding tag.
    do_reset();
    result(8'h77, 1'b1, 1'b0);
    idle(1);
    check("orphan_tag_err", 64'(bus.tag_err), 64'd1);
    check("orphan_res_valid", 64'(bus.res_valid), 64'd0);
    check("orphan_in_flight", 64'(bus.in_flight), 64'd0);

    // Result FIFO overflow while the consumer stalls, then drain.
    do_reset();
    rdy_g = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      issue(8'(i));
      result(8'h20 + 8'(i), 1'b0, (i == 3));
    end
    idle(3);
    check("resovf_ovf", 64'(bus.ovf_err), 64'd1);
    check("resovf_head_tag", 64'(bus.res_tag), 64'd1);
    rdy_g = 1'b1;
    idle(6);
    check("resovf_drained", 64'(n_rec), 64'd4);
    check("resovf_res_valid", 64'(bus.res_valid), 64'd0);

    // Full tag FIFO with a push and a pop in the same cycle.
    do_reset();
    for (int i = 1; i <= 4; i++) issue(8'(i));
    step(1'b0, 1'b1, 8'd5, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    check("fullpp_in_flight", 64'(bus.in_flight), 64'd4);
    check("fullpp_ovf", 64'(bus.ovf_err), 64'd0);
    for (int i = 0; i < 4; i++) result(8'h40 + 8'(i), 1'b1, 1'b0);
    idle(2);
    check("fullpp_records", 64'(n_rec), 64'd5);

    // Reset with tags and records outstanding, then fresh traffic.
    do_reset();
    rdy_g = 1'b0;
    issue(8'd1); issue(8'd2);
    result(8'h01, 1'b0, 1'b0);
    result(8'h02, 1'b0, 1'b0);
    issue(8'd3); issue(8'd4);
    check("midrst_in_flight", 64'(bus.in_flight), 64'd2);
    do_reset();
    rdy_g = 1'b1;
    issue(8'd9);
    result(8'h11, 1'b1, 1'b0);
    idle(2);
    check("midrst_records", 64'(n_rec), 64'd1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
      step(1'b0, ($urandom_range(0, 99) < 50), 8'($urandom()),
           ($urandom_range(0, 99) < 45), a, 1'($urandom()), (a == 8'h00),
           ($urandom_range(0, 99) < 60));
    end
    rdy_g = 1'b1;
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the ALU operand/result width.
REQ-002 Parameter TAG_W, default 8, SHALL set the packet-number (tag) width.
REQ-003 Parameter DEPTH, default 4, power of 2 and >= 2, SHALL set the depth of both the tag FIFO and the result FIFO.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 valid_in  in  1  snoop of the ALU issue strobe; one operation issued per high cycle.
REQ-007 pkt_num  in  TAG_W  tag of the operation issued when valid_in=1.
REQ-008 valid_out  in  1  ALU result strobe.
REQ-009 alu  in  DATA_W  ALU result, qualified by valid_out.
REQ-010 carry  in  1  ALU carry, qualified by valid_out.
REQ-011 zero  in  1  ALU zero flag, qualified by valid_out.
REQ-012 res_valid  out  1  result record available.
REQ-013 res_ready  in  1  consumer accepts the record.
REQ-014 res_tag  out  TAG_W  tag of the head record.
REQ-015 res_data  out  DATA_W  ALU result of the head record.
REQ-016 res_carry  out  1  carry of the head record.
REQ-017 res_zero  out  1  zero flag of the head record.
REQ-018 in_flight  out  clog2(DEPTH)+1  current tag FIFO occupancy.
REQ-019 zero_cnt  out  16  count of accepted results with zero=1.
REQ-020 ovf_err  out  1  sticky: an issue or a result was dropped.
REQ-021 tag_err  out  1  sticky: a result arrived with no outstanding tag.

Function
REQ-022 Tag FIFO SHALL push pkt_num on each cycle with valid_in=1 unless full-and-not-popping; a dropped push SHALL set ovf_err.
REQ-023 On valid_out=1 with tag FIFO non-empty, the head tag SHALL be popped and {tag, alu, carry, zero} pushed into the result FIFO (in-order matching).
REQ-024 On valid_out=1 with tag FIFO empty (occupancy at cycle start), the result SHALL be discarded, tag_err set, and no pop performed; a same-cycle valid_in push SHALL still occur.
REQ-025 Simultaneous tag push and pop SHALL both succeed, including when the tag FIFO is full; occupancy unchanged.
REQ-026 If the result FIFO is full and not popped that cycle, a matched result SHALL be dropped, its tag still popped, and ovf_err set.
REQ-027 res_valid SHALL be 1 iff the result FIFO is non-empty; res_* SHALL present the head record (first-word-fall-through) and hold stable while res_valid=1 and res_ready=0.
REQ-028 A record SHALL be popped when res_valid=1 and res_ready=1; simultaneous push and pop when full SHALL accept the push.
REQ-029 Latency: a result matched on valid_out at edge N SHALL be visible at res_* after edge N (res_valid=1 in cycle N+1) when the result FIFO was empty.
REQ-030 Read/write pointers SHALL wrap modulo DEPTH; occupancy counters SHALL distinguish full from empty.
REQ-031 zero_cnt SHALL increment by 1 per result pushed into the result FIFO with zero=1, saturating at 16'hFFFF.
REQ-032 in_flight SHALL equal tag FIFO occupancy after each edge.
REQ-033 ovf_err and tag_err SHALL remain set until reset.

Reset
REQ-034 With reset=1 at an edge, both FIFOs SHALL empty, pointers clear, and res_valid=0, res_tag=0, res_data=0, res_carry=0, res_zero=0, in_flight=0, zero_cnt=0, ovf_err=0, tag_err=0.
REQ-035 Reset SHALL take priority over all same-cycle valid_in, valid_out and res_ready activity; reset mid-operation SHALL discard all outstanding tags and records.

Verification
REQ-036 Issue tags 1,2,3 then results 8'h05/c0/z0, 8'h00/c1/z1, 8'hFF/c0/z0 with res_ready=1 -> records (1,05,0,0),(2,00,1,1),(3,FF,0,0) in order; zero_cnt=1; in_flight=0.
REQ-037 Issue 5 tags with DEPTH=4, no results -> in_flight=4, ovf_err=1; then 4 results -> tags 1..4 returned, fifth dropped.
REQ-038 valid_out=1 with no issued tag -> no record, tag_err=1, in_flight=0.
REQ-039 res_ready=0, 5 matched results -> 4 records held stable, ovf_err=1; res_ready=1 -> first 4 tags drained in order, res_valid=0 after.
REQ-040 Full tag FIFO with simultaneous valid_in and valid_out -> in_flight stays 4, no ovf_err.
REQ-041 Reset asserted with 2 tags and 2 records outstanding -> next cycle all outputs zero; subsequent tag 9 and result 8'h11 -> record (9,11,x,x).
